writeback_stage: RTL and testbench

Writeback stage of the RISC-V integer pipeline, sitting directly upstream of the integer register file and driving its single write port (`wr_en`, `rd_addr`, `rd_data`). It merges two result sources: the in-order ALU path (one result per cycle) and the load unit (variable latency, valid/ready handshake). Load results are buffered in a small FIFO and drained into idle write-port slots, with a starvation guard that periodically throttles the ALU. The stage also exports a pending-destination mask so decode can stall on hazards against buffered loads.

---
 rtl/writeback_stage.sv | 123 ++++++++++++
 tb/tb_writeback_stage.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/writeback_stage.sv
// Integer writeback stage: merges in-order ALU results with buffered load results
// onto the single register-file write port, with a starvation guard for loads.
module writeback_stage #(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd_addr,
    input  logic [31:0] alu_result,
    output logic        alu_ready,
    input  logic        lsu_valid,
    input  logic [4:0]  lsu_rd_addr,
    input  logic [31:0] lsu_data,
    output logic        lsu_ready,
    output logic        wr_en,
    output logic [4:0]  rd_addr,
    output logic [31:0] rd_data,
    output logic [31:0] pending
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [4:0]    fifo_rd_q   [DEPTH];
    logic [4:0]    fifo_rd_d   [DEPTH];
    logic [31:0]   fifo_data_q [DEPTH];
    logic [31:0]   fifo_data_d [DEPTH];
    logic [AW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          wr_en_q, wr_en_d;
    logic [4:0]    rd_addr_q, rd_addr_d;
    logic [31:0]   rd_data_q, rd_data_d;

    logic          empty, full, starved, alu_wr, pop, enq;
    logic [AW-1:0] rel;

    assign wr_en   = wr_en_q;
    assign rd_addr = rd_addr_q;
    assign rd_data = rd_data_q;

    always_comb begin
        empty     = (count_q == '0);
        full      = (count_q == CW'(DEPTH));
        starved   = (starve_q == SW'(STARVE_MAX)) && !empty;
        alu_ready = !starved;
        lsu_ready = !full;
        alu_wr    = alu_valid && alu_ready && (alu_rd_addr != 5'd0);
        // An ALU write to x0 leaves the port free, so the FIFO may drain
        pop       = !empty && !alu_wr;
        enq       = lsu_valid && lsu_ready && (lsu_rd_addr != 5'd0);
    end

    always_comb begin
        fifo_rd_d   = fifo_rd_q;
        fifo_data_d = fifo_data_q;
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q + CW'(enq) - CW'(pop);
        wr_en_d     = alu_wr || pop;
        rd_addr_d   = rd_addr_q;
        rd_data_d   = rd_data_q;
        starve_d    = starve_q;

        if (enq) begin
            fifo_rd_d[tail_q]   = lsu_rd_addr;
            fifo_data_d[tail_q] = lsu_data;
            tail_d              = tail_q + AW'(1);
        end
        if (pop) begin
            head_d    = head_q + AW'(1);
            rd_addr_d = fifo_rd_q[head_q];
            rd_data_d = fifo_data_q[head_q];
        end else if (alu_wr) begin
            rd_addr_d = alu_rd_addr;
            rd_data_d = alu_result;
        end

        if (empty || pop) begin
            starve_d = '0;
        end else if (alu_wr && (starve_q != SW'(STARVE_MAX))) begin
            starve_d = starve_q + SW'(1);
        end
    end

    // Entry i is live when its distance from head is below occupancy
    always_comb begin
        pending = '0;
        rel     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            rel = AW'(i) - head_q;
            if (CW'(rel) < count_q) pending[fifo_rd_q[i]] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_rd_q[i]   <= '0;
                fifo_data_q[i] <= '0;
            end
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            starve_q  <= '0;
            wr_en_q   <= 1'b0;
            rd_addr_q <= '0;
            rd_data_q <= '0;
        end else begin
            fifo_rd_q   <= fifo_rd_d;
            fifo_data_q <= fifo_data_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            starve_q    <= starve_d;
            wr_en_q     <= wr_en_d;
            rd_addr_q   <= rd_addr_d;
            rd_data_q   <= rd_data_d;
        end
    end
endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: vector table plus hand sequences for
// backpressure/starvation, pointer wrap and asynchronous reset.
module tb_writeback_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, alu_ready, lsu_valid, lsu_ready, wr_en;
    logic [4:0]  alu_rd_addr, lsu_rd_addr, rd_addr;
    logic [31:0] alu_result, lsu_data, rd_data, pending;

    writeback_stage #(.DEPTH(2), .STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd_addr(alu_rd_addr), .alu_result(alu_result), .alu_ready(alu_ready),
        .lsu_valid(lsu_valid), .lsu_rd_addr(lsu_rd_addr), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
        .wr_en(wr_en), .rd_addr(rd_addr), .rd_data(rd_data), .pending(pending)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [36:0] wq[$];

    always @(negedge clk) if (wr_en) wq.push_back({rd_addr, rd_data});

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] ares,
                         input logic lv, input logic [4:0] lrd, input logic [31:0] ldat);
        alu_valid = av; alu_rd_addr = ard; alu_result = ares;
        lsu_valid = lv; lsu_rd_addr = lrd; lsu_data = ldat;
    endtask

    typedef struct {
        logic        av;
        logic [4:0]  ard;
        logic [31:0] ares;
        logic        lv;
        logic [4:0]  lrd;
        logic [31:0] ldat;
        logic [31:0] e_pend;
        logic        e_wr;
        logic [4:0]  e_rd;
        logic [31:0] e_data;
    } vec_t;

    function automatic vec_t mk(logic av, logic [4:0] ard, logic [31:0] ares,
                                logic lv, logic [4:0] lrd, logic [31:0] ldat,
                                logic [31:0] e_pend, logic e_wr, logic [4:0] e_rd, logic [31:0] e_data);
        vec_t v;
        v.av = av; v.ard = ard; v.ares = ares; v.lv = lv; v.lrd = lrd; v.ldat = ldat;
        v.e_pend = e_pend; v.e_wr = e_wr; v.e_rd = e_rd; v.e_data = e_data;
        return v;
    endfunction

    vec_t tbl[18];

    initial begin
        int first_low, l3_acc, li, n;
        logic rdy_a[25];
        logic rdy_l[25];
        logic [36:0] e;

        // pending / wr columns: pending is sampled during the cycle, write after the edge
        tbl[0]  = mk(1, 5, 32'hDEADBEEF, 0, 0, 0,           32'h0,     1, 5, 32'hDEADBEEF);
        tbl[1]  = mk(1, 0, 32'h111,      0, 0, 0,           32'h0,     0, 0, 0);
        tbl[2]  = mk(0, 0, 0,            1, 7, 32'h12345678, 32'h0,    0, 0, 0);
        tbl[3]  = mk(0, 0, 0,            0, 0, 0,           32'h80,    1, 7, 32'h12345678);
        tbl[4]  = mk(0, 0, 0,            0, 0, 0,           32'h0,     0, 0, 0);
        tbl[5]  = mk(0, 0, 0,            1, 9, 32'h1,       32'h0,     0, 0, 0);
        tbl[6]  = mk(0, 0, 0,            1, 9, 32'h2,       32'h200,   1, 9, 32'h1);
        tbl[7]  = mk(0, 0, 0,            0, 0, 0,           32'h200,   1, 9, 32'h2);
        tbl[8]  = mk(0, 0, 0,            0, 0, 0,           32'h0,     0, 0, 0);
        tbl[9]  = mk(0, 0, 0,            1, 3, 32'hAA,      32'h0,     0, 0, 0);
        tbl[10] = mk(1, 0, 32'h55,       0, 0, 0,           32'h8,     1, 3, 32'hAA);
        tbl[11] = mk(0, 0, 0,            0, 0, 0,           32'h0,     0, 0, 0);
        tbl[12] = mk(0, 0, 0,            1, 0, 32'hBB,      32'h0,     0, 0, 0);
        tbl[13] = mk(0, 0, 0,            0, 0, 0,           32'h0,     0, 0, 0);
        tbl[14] = mk(1, 4, 32'h44,       1, 6, 32'h66,      32'h0,     1, 4, 32'h44);
        tbl[15] = mk(1, 8, 32'h88,       0, 0, 0,           32'h40,    1, 8, 32'h88);
        tbl[16] = mk(0, 0, 0,            0, 0, 0,           32'h40,    1, 6, 32'h66);
        tbl[17] = mk(0, 0, 0,            0, 0, 0,           32'h0,     0, 0, 0);

        rst = 1'b0;
        drive(1, 5, 32'hFFFF_FFFF, 1, 5, 32'hFFFF_FFFF);
        repeat (2) @(posedge clk);
        #1;
        chk("reset wr_en", 32'(wr_en), 0);
        chk("reset rd_addr", 32'(rd_addr), 0);
        chk("reset rd_data", rd_data, 0);
        chk("reset pending", pending, 0);
        chk("reset alu_ready", 32'(alu_ready), 1);
        chk("reset lsu_ready", 32'(lsu_ready), 1);
        @(negedge clk);
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;

        for (int k = 0; k < 18; k++) begin
            drive(tbl[k].av, tbl[k].ard, tbl[k].ares, tbl[k].lv, tbl[k].lrd, tbl[k].ldat);
            @(negedge clk);
            chk($sformatf("v%0d pending", k), pending, tbl[k].e_pend);
            chk($sformatf("v%0d alu_ready", k), 32'(alu_ready), 1);
            chk($sformatf("v%0d lsu_ready", k), 32'(lsu_ready), 1);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d wr_en", k), 32'(wr_en), 32'(tbl[k].e_wr));
            if (tbl[k].e_wr) begin
                chk($sformatf("v%0d rd_addr", k), 32'(rd_addr), 32'(tbl[k].e_rd));
                chk($sformatf("v%0d rd_data", k), rd_data, tbl[k].e_data);
            end
        end
        drive(0, 0, 0, 0, 0, 0);

        // Backpressure and starvation: ALU busy every cycle, three loads offered
        wq.delete();
        first_low = -1; l3_acc = -1; li = 0;
        for (int c = 0; c < 25; c++) begin
            drive(c < 20, 5'd1, 32'(c), li < 3, 5'(20 + li), 32'hA0 + 32'(li));
            @(negedge clk);
            rdy_a[c] = alu_ready;
            rdy_l[c] = lsu_ready;
            if (!alu_ready && first_low < 0) first_low = c;
            if (lsu_valid && lsu_ready) begin
                if (li == 2) l3_acc = c;
                li++;
            end
            @(posedge clk);
            #1;
        end
        drive(0, 0, 0, 0, 0, 0);
        chk("bp first alu_ready drop", 32'(first_low), 5);
        chk("bp alu_ready c4", 32'(rdy_a[4]), 1);
        chk("bp alu_ready c6", 32'(rdy_a[6]), 1);
        chk("bp alu_ready c10", 32'(rdy_a[10]), 0);
        chk("bp lsu_ready c2", 32'(rdy_l[2]), 0);
        chk("bp lsu_ready pop cycle", 32'(rdy_l[5]), 0);
        chk("bp lsu_ready after pop", 32'(rdy_l[6]), 1);
        chk("bp third load accept cycle", 32'(l3_acc), 6);
        n = 0;
        foreach (wq[i]) begin
            if (wq[i][36:32] >= 5'd20) begin
                e = {5'(20 + n), 32'hA0 + 32'(n)};
                chk($sformatf("bp load order %0d", n), wq[i][31:0] ^ {27'd0, wq[i][36:32]},
                    e[31:0] ^ {27'd0, e[36:32]});
                n++;
            end
        end
        chk("bp load write count", 32'(n), 3);

        // Pointer wrap: ten back-to-back loads, ALU idle
        wq.delete();
        for (int i = 0; i < 10; i++) begin
            drive(0, 0, 0, 1, 5'(10 + i), 32'h1000 + 32'(i));
            @(negedge clk);
            chk($sformatf("wrap lsu_ready %0d", i), 32'(lsu_ready), 1);
            @(posedge clk);
            #1;
        end
        drive(0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("wrap write count", 32'(wq.size()), 10);
        for (int i = 0; i < 10 && i < wq.size(); i++) begin
            chk($sformatf("wrap rd %0d", i), 32'(wq[i][36:32]), 32'(10 + i));
            chk($sformatf("wrap data %0d", i), wq[i][31:0], 32'h1000 + 32'(i));
        end

        // Asynchronous reset with two buffered loads
        drive(1, 1, 32'h77, 1, 25, 32'h250);
        @(posedge clk); #1;
        drive(1, 1, 32'h78, 1, 26, 32'h260);
        @(posedge clk); #1;
        drive(1, 1, 32'h79, 0, 0, 0);
        @(posedge clk); #3;
        chk("pre-reset pending", pending, 32'h0600_0000);
        chk("pre-reset wr_en", 32'(wr_en), 1);
        rst = 1'b0;
        #1;
        chk("async reset wr_en", 32'(wr_en), 0);
        chk("async reset rd_addr", 32'(rd_addr), 0);
        chk("async reset rd_data", rd_data, 0);
        chk("async reset pending", pending, 0);
        chk("async reset lsu_ready", 32'(lsu_ready), 1);
        chk("async reset alu_ready", 32'(alu_ready), 1);
        drive(1, 2, 32'h99, 1, 27, 32'h270);
        repeat (2) @(posedge clk);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        wq.delete();
        repeat (5) @(posedge clk);
        #1;
        chk("post-reset writes", 32'(wq.size()), 0);
        chk("post-reset pending", pending, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
